// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the front-panel button event controller.
package btn_evt_pkg;

    typedef enum logic [1:0] {EVT_SHORT, EVT_LONG, EVT_LONG_REL, EVT_REPEAT} evt_kind_e;

    typedef enum logic [1:0] {BTN_IDLE, BTN_PRESSED, BTN_LONG_HELD} btn_state_e;

    typedef struct packed {
        logic      vld;
        evt_kind_e kind;
    } pend_slot_t;

    // Width of a counter whose terminal value is max_val (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/btn_filter.sv
// One button channel: 2-FF synchroniser followed by a stability counter that only moves
// btn_level once the synchronised input has held the same value for DEBOUNCE_CYCLES cycles.
module btn_filter
    import btn_evt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             cand_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            cand_q    <= 1'b0;
            cnt_q     <= '0;
            btn_level <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            if (sync_q2 != cand_q) begin
                cand_q <= sync_q2;
                cnt_q  <= '0;
            end else if (cnt_q == CNT_TERM) begin
                // Counter parks at the terminal value, so the level simply tracks the candidate.
                btn_level <= cand_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: per-channel filter and short/long classifier, one pending slot
// per channel, and a round-robin arbiter feeding a registered valid/ready event port.
// Optional auto-repeat while a long press is held: define BTN_AUTOREPEAT_EN.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter int unsigned LONG_CYCLES     = 500000,
    parameter int unsigned REPEAT_CYCLES   = 100000,
    localparam int unsigned ID_W           = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic [1:0]         evt_kind,
    output logic               evt_drop
);

    localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REP_W = cnt_width(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_TERM = REP_W'(REPEAT_CYCLES - 1);
`endif

    if (NUM_BTN < 1 || NUM_BTN > 16 || DEBOUNCE_CYCLES == 0 || LONG_CYCLES == 0 ||
        REPEAT_CYCLES == 0) begin : g_param_check
        $error("button_event_ctrl: parameter out of range");
    end

    logic [NUM_BTN-1:0] post_vld;
    evt_kind_e          post_kind [NUM_BTN];

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_state_e        state_q;
        logic [HOLD_W-1:0] hold_q;
        logic              post_vld_q;
        evt_kind_e         post_kind_q;
`ifdef BTN_AUTOREPEAT_EN
        logic [REP_W-1:0]  rep_q;
`endif

        btn_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filter (
            .clock    (clock),
            .reset    (reset),
            .btn_raw  (btn_raw[g]),
            .btn_level(btn_level[g])
        );

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q     <= BTN_IDLE;
                hold_q      <= '0;
                post_vld_q  <= 1'b0;
                post_kind_q <= EVT_SHORT;
`ifdef BTN_AUTOREPEAT_EN
                rep_q       <= '0;
`endif
            end else begin
                post_vld_q <= 1'b0;
                case (state_q)
                    BTN_IDLE: begin
                        if (btn_level[g]) begin
                            state_q <= BTN_PRESSED;
                            hold_q  <= '0;
                        end
                    end
                    BTN_PRESSED: begin
                        if (!btn_level[g]) begin
                            post_vld_q  <= 1'b1;
                            post_kind_q <= EVT_SHORT;
                            state_q     <= BTN_IDLE;
                        end else if (hold_q == HOLD_TERM) begin
                            post_vld_q  <= 1'b1;
                            post_kind_q <= EVT_LONG;
                            state_q     <= BTN_LONG_HELD;
`ifdef BTN_AUTOREPEAT_EN
                            rep_q       <= '0;
`endif
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    BTN_LONG_HELD: begin
                        if (!btn_level[g]) begin
                            post_vld_q  <= 1'b1;
                            post_kind_q <= EVT_LONG_REL;
                            state_q     <= BTN_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                        end else if (rep_q == REP_TERM) begin
                            post_vld_q  <= 1'b1;
                            post_kind_q <= EVT_REPEAT;
                            rep_q       <= '0;
                        end else begin
                            rep_q <= rep_q + 1'b1;
`endif
                        end
                    end
                    default: state_q <= BTN_IDLE;
                endcase
            end
        end

        assign post_vld[g]  = post_vld_q;
        assign post_kind[g] = post_kind_q;
    end

    pend_slot_t         slot_q [NUM_BTN];
    pend_slot_t         slot_d [NUM_BTN];
    logic [NUM_BTN-1:0] avail;
    evt_kind_e          avail_kind [NUM_BTN];
    logic               load;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    scan_idx;
    logic [ID_W-1:0]    rr_q;
    logic               drop_any;
    logic               evt_valid_q;
    logic [ID_W-1:0]    evt_id_q;
    evt_kind_e          evt_kind_q;
    logic               evt_drop_q;

    // A post bypasses its empty slot so it can reach the output register in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            avail[i]      = slot_q[i].vld | post_vld[i];
            avail_kind[i] = slot_q[i].vld ? slot_q[i].kind : post_kind[i];
        end
    end

    assign load = !evt_valid_q || evt_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned off = 0; off < NUM_BTN; off++) begin
            scan_idx = ID_W'((32'(rr_q) + off) % NUM_BTN);
            if (!grant_found && avail[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        drop_any = 1'b0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            slot_d[i] = slot_q[i];
            if (load && grant_found && grant_idx == ID_W'(i)) begin
                // Old contents leave; a simultaneous post refills the freed slot.
                slot_d[i].vld  = slot_q[i].vld && post_vld[i];
                slot_d[i].kind = post_kind[i];
            end else if (post_vld[i]) begin
                if (!slot_q[i].vld) begin
                    slot_d[i].vld  = 1'b1;
                    slot_d[i].kind = post_kind[i];
                end else if (post_kind[i] != EVT_REPEAT) begin
                    drop_any = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                slot_q[i] <= '0;
            end
            rr_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_kind_q  <= EVT_SHORT;
            evt_drop_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                slot_q[i] <= slot_d[i];
            end
            evt_drop_q <= drop_any;
            if (load) begin
                evt_valid_q <= grant_found;
                if (grant_found) begin
                    evt_id_q   <= grant_idx;
                    evt_kind_q <= avail_kind[grant_idx];
                    rr_q       <= ID_W'((32'(grant_idx) + 32'd1) % NUM_BTN);
                end
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_kind  = evt_kind_q;
    assign evt_drop  = evt_drop_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: directed scenarios plus randomized presses; expected
// event kinds are derived from press durations and queued per channel.
module tb_button_event_ctrl;

    localparam int unsigned NB  = 4;
    localparam int unsigned DEB = 8;
    localparam int unsigned LNG = 40;
    localparam int unsigned REP = 16;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic [NB-1:0] btn_raw   = '0;
    logic [NB-1:0] btn_level;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [1:0]    evt_id;
    logic [1:0]    evt_kind;
    logic          evt_drop;

    int            errors       = 0;
    int            checks       = 0;
    int unsigned   cyc          = 0;
    int            hs_count     = 0;
    int            nonrep_count = 0;
    int            drop_count   = 0;
    int            valid_cycles = 0;
    int            long_cyc     = 0;
    int            rel_cyc      = 0;
    logic [NB-1:0] level_seen   = '0;
    logic          rnd_done     = 1'b0;
    int            hs_id_log [$];
    int            hs_cyc_log [$];
    logic [1:0]    exp_q [NB][$];

    button_event_ctrl #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_kind (evt_kind),
        .evt_drop (evt_drop)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input int ch, input int dur);
        btn_raw[2'(ch)] = 1'b1;
        tick(dur);
        btn_raw[2'(ch)] = 1'b0;
    endtask

    // Random clean presses on one channel; kind follows from the held duration alone.
    task automatic chan_proc(input int ch);
        int gap;
        int dur;
        int g;
        for (int p = 0; p < 4; p++) begin
            gap = int'($urandom_range(DEB + 4, DEB + 20));
            tick(gap);
            if ($urandom_range(0, 1) == 1) begin
                g = int'($urandom_range(1, DEB - 3));
                press(ch, g);
                tick(DEB + 4);
            end
            if ($urandom_range(0, 1) == 1) begin
                dur = int'($urandom_range(LNG + 15, LNG + 40));
                exp_q[ch].push_back(2'd1);
                exp_q[ch].push_back(2'd2);
            end else begin
                dur = int'($urandom_range(DEB + 2, LNG - 5));
                exp_q[ch].push_back(2'd0);
            end
            press(ch, dur);
        end
        tick(DEB + 20);
    endtask

    // Monitor: pops the expected kind for the channel of every accepted event.
    initial begin : monitor
        logic       stall;
        logic [1:0] st_id;
        logic [1:0] st_kind;
        logic [1:0] exp_k;
        stall   = 1'b0;
        st_id   = '0;
        st_kind = '0;
        forever begin
            @(negedge clock);
            level_seen = level_seen | btn_level;
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("held_output", int'({evt_valid, evt_id, evt_kind}),
                          int'({1'b1, st_id, st_kind}));
                end
                if (evt_valid) valid_cycles++;
                if (evt_drop) drop_count++;
                if (evt_valid && evt_ready) begin
                    hs_count++;
                    hs_id_log.push_back(int'(evt_id));
                    hs_cyc_log.push_back(int'(cyc));
                    if (evt_kind == 2'd1) long_cyc = int'(cyc);
                    if (evt_kind == 2'd2) rel_cyc = int'(cyc);
`ifdef BTN_AUTOREPEAT_EN
                    if (evt_kind != 2'd3) begin
`else
                    begin
`endif
                        nonrep_count++;
                        if (exp_q[evt_id].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_event: got id %0d kind %0d, expected none",
                                     evt_id, evt_kind);
                        end else begin
                            exp_k = exp_q[evt_id].pop_front();
                            check("event_kind", int'(evt_kind), int'(exp_k));
                        end
                    end
                end
                stall   = evt_valid && !evt_ready;
                st_id   = evt_id;
                st_kind = evt_kind;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        int hs0;
        int nr0;
        int vc0;
        int d0;
        int t0;
        int b;
        int pend;

        // Reset values
        reset = 1'b1;
        tick(3);
        @(negedge clock);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_id", int'(evt_id), 0);
        check("rst_evt_kind", int'(evt_kind), 0);
        check("rst_evt_drop", int'(evt_drop), 0);
        check("rst_btn_level", int'(btn_level), 0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Test 1: glitch rejection
        evt_ready  = 1'b1;
        level_seen = '0;
        hs0        = hs_count;
        for (int k = 0; k < 30; k++) begin
            btn_raw[0] = ((k / 3) % 2) == 0;
            tick(1);
        end
        btn_raw[0] = 1'b0;
        tick(30);
        check("t1_level0", int'(level_seen[0]), 0);
        check("t1_events", hs_count - hs0, 0);

        // Test 2: short press on channel 1
        hs0 = hs_count;
        vc0 = valid_cycles;
        exp_q[1].push_back(2'd0);
        press(1, 20);
        tick(40);
        check("t2_events", hs_count - hs0, 1);
        check("t2_valid_cycles", valid_cycles - vc0, 1);
        check("t2_id", hs_id_log[hs_id_log.size() - 1], 1);

        // Test 3: long press on channel 2
        nr0 = nonrep_count;
        exp_q[2].push_back(2'd1);
        exp_q[2].push_back(2'd2);
        btn_raw[2] = 1'b1;
        t0 = int'(cyc);
        tick(100);
        btn_raw[2] = 1'b0;
        b = int'(cyc);
        tick(40);
        check("t3_events", nonrep_count - nr0, 2);
        check("t3_long_window", int'((long_cyc - t0) >= 48 && (long_cyc - t0) <= 58), 1);
        check("t3_rel_window", int'((rel_cyc - b) >= int'(DEB) + 2 && (rel_cyc - b) <= int'(DEB) + 8), 1);

        // Test 4: fairness after a fresh reset (pointer back at 0)
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        for (int burst = 0; burst < 2; burst++) begin
            b = hs_id_log.size();
            for (int c = 0; c < int'(NB); c++) exp_q[c].push_back(2'd0);
            btn_raw = '1;
            tick(20);
            btn_raw = '0;
            tick(30);
            check("t4_events", hs_id_log.size() - b, int'(NB));
            if (hs_id_log.size() - b == int'(NB)) begin
                for (int k = 0; k < int'(NB); k++) check("t4_order", hs_id_log[b + k], k);
                for (int k = 0; k < int'(NB) - 1; k++) begin
                    check("t4_consecutive", hs_cyc_log[b + k + 1] - hs_cyc_log[b + k], 1);
                end
            end
        end

        // Test 5: backpressure on channel 3
        evt_ready = 1'b0;
        hs0 = hs_count;
        d0  = drop_count;
        exp_q[3].push_back(2'd0);
        exp_q[3].push_back(2'd1);
        press(3, 20);
        tick(30);
        @(negedge clock);
        check("t5_valid", int'(evt_valid), 1);
        check("t5_id", int'(evt_id), 3);
        check("t5_kind", int'(evt_kind), 0);
        tick(1);
        press(3, 60);
        tick(40);
        check("t5_drops", drop_count - d0, 1);
        evt_ready = 1'b1;
        tick(10);
        check("t5_events", hs_count - hs0, 2);
        check("t5_queue_empty", exp_q[3].size(), 0);

        // Test 6: reset while channel 0 is held and a channel 1 event is pending
        evt_ready = 1'b0;
        press(1, 20);
        tick(30);
        @(negedge clock);
        check("t6_pending", int'(evt_valid), 1);
        tick(1);
        btn_raw[0] = 1'b1;
        tick(20);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge clock);
        check("t6_valid_after_reset", int'(evt_valid), 0);
        tick(1);
        evt_ready = 1'b1;
        hs0 = hs_count;
        tick(25);
        check("t6_no_event_held", hs_count - hs0, 0);
        exp_q[0].push_back(2'd0);
        btn_raw[0] = 1'b0;
        tick(30);
        check("t6_release_event", hs_count - hs0, 1);
        exp_q[0].push_back(2'd0);
        press(0, 20);
        tick(30);
        check("t6_repress_event", hs_count - hs0, 2);

        // Randomized presses on all channels with random backpressure
        d0 = drop_count;
        rnd_done = 1'b0;
        fork
            begin
                fork
                    chan_proc(0);
                    chan_proc(1);
                    chan_proc(2);
                    chan_proc(3);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    evt_ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            end
        join
        evt_ready = 1'b1;
        pend = 1;
        for (int w = 0; w < 300 && pend != 0; w++) begin
            tick(1);
            pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
        end
        for (int c = 0; c < int'(NB); c++) check("rnd_queue_empty", exp_q[c].size(), 0);
        check("rnd_drops", drop_count - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
